// File: rtl/sdio_pkg.sv
// Shared definitions for the SDIO bus responder.
//   bus_state_e : responder FSM state (IDLE accepts requests, BUSY runs wait count)
//   OOR_RDATA   : data returned for a read outside the implemented memory
package sdio_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } bus_state_e;

  localparam logic [7:0] OOR_RDATA = 8'hFF;

endpackage

// File: rtl/sdio_spram.sv
// Single-port 2^AW x 8 synchronous RAM with registered read.
//   clk   : clock
//   en    : access enable
//   we    : 1 = write wdata to addr, 0 = read addr into q
//   addr  : byte address
//   wdata : write data
//   q     : read data register, updated only by reads, holds otherwise
module sdio_spram #(
  parameter int unsigned AW = 8
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    q
);

  logic [7:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        q <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/sdio_bus_mem.sv
// Byte-wide SDIO DMA bus target backed by an internal SRAM, with a
// low-priority CPU port sharing the same memory.
//   bus_clk, rst                 : clock, synchronous active-high reset
//   bus_rd/bus_wr/bus_addr/bus_wdata : single-byte request, taken when bus_ready
//   bus_ready                    : idle, request may be presented
//   bus_rdata_ready/bus_rdata    : one-cycle read-data pulse / read data
//   cpu_en/cpu_we/cpu_addr/cpu_wdata : CPU access request (level, held to ack)
//   cpu_ack/cpu_rdata            : one-cycle completion pulse / read data
//   err_clr, err_oor, err_proto  : sticky error flags and their clear
module sdio_bus_mem
  import sdio_pkg::*;
#(
  parameter int unsigned LEN  = 16,
  parameter int unsigned AW   = 8,
  parameter int unsigned WAIT = 2
) (
  input  logic           bus_clk,
  input  logic           rst,
  input  logic           bus_rd,
  input  logic           bus_wr,
  input  logic [LEN-1:0] bus_addr,
  input  logic [7:0]     bus_wdata,
  output logic           bus_ready,
  output logic           bus_rdata_ready,
  output logic [7:0]     bus_rdata,
  input  logic           cpu_en,
  input  logic           cpu_we,
  input  logic [AW-1:0]  cpu_addr,
  input  logic [7:0]     cpu_wdata,
  output logic           cpu_ack,
  output logic [7:0]     cpu_rdata,
  input  logic           err_clr,
  output logic           err_oor,
  output logic           err_proto
);

  bus_state_e     state;
  logic [3:0]     wait_cnt;
  logic           req_we;
  logic [LEN-1:0] req_addr;
  logic [7:0]     req_wdata;
  logic           cpu_rd_q;

  logic           ram_en;
  logic           ram_we;
  logic [AW-1:0]  ram_addr;
  logic [7:0]     ram_wdata;
  logic [7:0]     ram_q;

  logic           can_accept;
  logic           any_req;
  logic           both_req;
  logic           cpu_go;
  logic           finish;
  logic           req_oor;

  // bus_ready doubles as the "out of reset" qualifier for the IDLE state.
  assign can_accept = (state == IDLE) && bus_ready;
  assign any_req    = bus_rd | bus_wr;
  assign both_req   = bus_rd & bus_wr;
  assign cpu_go     = can_accept && !any_req && cpu_en;
  assign finish     = (state == BUSY) && (wait_cnt == 4'd1);
  assign req_oor    = (req_addr >> AW) != '0;

  // The RAM read for a bus request is issued in the acceptance cycle so its
  // registered output is ready by the end of the wait; nothing else touches
  // the RAM while BUSY, so ram_q holds until the final cycle.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = req_addr[AW-1:0];
    ram_wdata = req_wdata;
    if (!rst) begin
      if (finish) begin
        if (req_we && !req_oor) begin
          ram_en = 1'b1;
          ram_we = 1'b1;
        end
      end else if (can_accept && bus_rd && !bus_wr) begin
        ram_en   = 1'b1;
        ram_addr = bus_addr[AW-1:0];
      end else if (cpu_go) begin
        ram_en    = 1'b1;
        ram_we    = cpu_we;
        ram_addr  = cpu_addr;
        ram_wdata = cpu_wdata;
      end
    end
  end

  sdio_spram #(
    .AW (AW)
  ) u_ram (
    .clk   (bus_clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .q     (ram_q)
  );

  // CPU read data comes straight from the RAM output register in the ack cycle.
  assign cpu_rdata = cpu_rd_q ? ram_q : '0;

  always_ff @(posedge bus_clk) begin
    if (rst) begin
      state           <= IDLE;
      wait_cnt        <= '0;
      req_we          <= 1'b0;
      req_addr        <= '0;
      req_wdata       <= '0;
      bus_ready       <= 1'b0;
      bus_rdata_ready <= 1'b0;
      bus_rdata       <= '0;
      cpu_ack         <= 1'b0;
      cpu_rd_q        <= 1'b0;
      err_oor         <= 1'b0;
      err_proto       <= 1'b0;
    end else begin
      bus_rdata_ready <= 1'b0;
      cpu_ack         <= 1'b0;
      cpu_rd_q        <= 1'b0;
      // Clear first so a same-cycle set below takes precedence.
      if (err_clr) begin
        err_oor   <= 1'b0;
        err_proto <= 1'b0;
      end
      case (state)
        IDLE: begin
          bus_ready <= 1'b1;
          if (can_accept) begin
            if (both_req) begin
              err_proto <= 1'b1;
            end else if (any_req) begin
              state     <= BUSY;
              wait_cnt  <= 4'(WAIT);
              req_we    <= bus_wr;
              req_addr  <= bus_addr;
              req_wdata <= bus_wdata;
              bus_ready <= 1'b0;
            end else if (cpu_en) begin
              cpu_ack  <= 1'b1;
              cpu_rd_q <= !cpu_we;
            end
          end
        end
        BUSY: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (any_req) begin
            err_proto <= 1'b1;
          end
          if (finish) begin
            state     <= IDLE;
            bus_ready <= 1'b1;
            if (req_oor) begin
              err_oor <= 1'b1;
            end
            if (!req_we) begin
              bus_rdata_ready <= 1'b1;
              bus_rdata       <= req_oor ? OOR_RDATA : ram_q;
            end
          end
        end
      endcase
    end
  end

endmodule
